// File: rtl/pipe_instr_tracker.sv
// Stage-instruction tracker for the five-stage MIPS pipeline: carries E/M/W instructions with
// their destination register and remaining new-value latency, plus a saturating stall counter.
module pipe_instr_tracker (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_I,
   input  logic        stall,
   output logic [31:0] ex_I,
   output logic [31:0] mem_I,
   output logic [31:0] wb_I,
   output logic [4:0]  ex_A3,
   output logic [4:0]  mem_A3,
   output logic [4:0]  wb_A3,
   output logic [1:0]  ex_Tnew,
   output logic [1:0]  mem_Tnew,
   output logic [31:0] stall_cnt
);

   // Returns {A3, Tnew}; lw vs subu share the value 0x23 but in different fields.
   function automatic logic [6:0] decode(input logic [31:0] instr);
      logic [6:0] res;
      res = 7'd0;
      case (instr[31:26])
         6'h00: begin
            case (instr[5:0])
               6'h21, 6'h23: res = {instr[15:11], 2'd1};
               6'h08:        res = 7'd0;
               default:      res = 7'd0;
            endcase
         end
         6'h0d, 6'h0f: res = {instr[20:16], 2'd1};
         6'h23:        res = {instr[20:16], 2'd2};
         6'h03:        res = {5'd31, 2'd0};
         default:      res = 7'd0;
      endcase
      return res;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] x);
      return (x != 2'd0) ? (x - 2'd1) : 2'd0;
   endfunction

   logic [6:0] dec_s;

   // Combinational decode of the D-stage instruction.
   always_comb begin
      dec_s = decode(d_I);
   end

   // Pipeline stage registers and stall counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_I      <= 32'd0;
         ex_A3     <= 5'd0;
         ex_Tnew   <= 2'd0;
         mem_I     <= 32'd0;
         mem_A3    <= 5'd0;
         mem_Tnew  <= 2'd0;
         wb_I      <= 32'd0;
         wb_A3     <= 5'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (stall) begin
            ex_I    <= 32'd0;
            ex_A3   <= 5'd0;
            ex_Tnew <= 2'd0;
         end else begin
            ex_I    <= d_I;
            ex_A3   <= dec_s[6:2];
            ex_Tnew <= dec_s[1:0];
         end
         mem_I    <= ex_I;
         mem_A3   <= ex_A3;
         mem_Tnew <= sat_dec(ex_Tnew);
         wb_I     <= mem_I;
         wb_A3    <= mem_A3;
         // Saturate rather than wrap so long runs never under-report stalls.
         if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

endmodule

// File: tb/tb_pipe_instr_tracker.sv
// Directed self-checking bench for pipe_instr_tracker.
module tb_pipe_instr_tracker;

   logic        clk;
   logic        reset;
   logic [31:0] d_I;
   logic        stall;
   logic [31:0] ex_I, mem_I, wb_I, stall_cnt;
   logic [4:0]  ex_A3, mem_A3, wb_A3;
   logic [1:0]  ex_Tnew, mem_Tnew;
   logic [146:0] all_out;

   int tests;
   int fails;

   localparam logic [31:0] ORI  = 32'h34250064;
   localparam logic [31:0] ADDU = 32'h00a20821;
   localparam logic [31:0] LW   = 32'h8c280000;

   pipe_instr_tracker dut (
      .clk(clk), .reset(reset), .d_I(d_I), .stall(stall),
      .ex_I(ex_I), .mem_I(mem_I), .wb_I(wb_I),
      .ex_A3(ex_A3), .mem_A3(mem_A3), .wb_A3(wb_A3),
      .ex_Tnew(ex_Tnew), .mem_Tnew(mem_Tnew), .stall_cnt(stall_cnt)
   );

   assign all_out = {ex_I, mem_I, wb_I, ex_A3, mem_A3, wb_A3, ex_Tnew, mem_Tnew, stall_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      d_I   = 32'd0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      d_I = 32'hdeadbeef;
      reset = 1'b1;
      #1;
      tests++;
      if (all_out !== 147'd0) begin
         fails++;
         $display("FAIL reset_async: got %h expected 0", all_out);
      end
      step();
      reset = 1'b0;
      d_I = ORI;
      step();
      tests++;
      if (ex_I !== ORI) begin
         fails++;
         $display("FAIL reset_first_load: got %h expected %h", ex_I, ORI);
      end
   endtask

   task automatic test_shift();
      do_reset();
      d_I = ORI;
      step();
      d_I = ADDU;
      step();
      tests++;
      if ({ex_I, ex_A3, ex_Tnew} !== {ADDU, 5'd1, 2'd1}) begin
         fails++;
         $display("FAIL shift_ex: got %h/%0d/%0d expected %h/1/1", ex_I, ex_A3, ex_Tnew, ADDU);
      end
      tests++;
      if ({mem_I, mem_A3, mem_Tnew} !== {ORI, 5'd5, 2'd0}) begin
         fails++;
         $display("FAIL shift_mem: got %h/%0d/%0d expected %h/5/0", mem_I, mem_A3, mem_Tnew, ORI);
      end
      d_I = 32'd0;
      step();
      tests++;
      if ({wb_I, wb_A3} !== {ORI, 5'd5}) begin
         fails++;
         $display("FAIL shift_wb: got %h/%0d expected %h/5", wb_I, wb_A3, ORI);
      end
      tests++;
      if ({ex_I, ex_A3, mem_I, mem_A3, mem_Tnew} !== {32'd0, 5'd0, ADDU, 5'd1, 2'd0}) begin
         fails++;
         $display("FAIL shift_ex_mem3: got %h/%0d %h/%0d/%0d expected 0/0 %h/1/0",
                  ex_I, ex_A3, mem_I, mem_A3, mem_Tnew, ADDU);
      end
   endtask

   task automatic test_lw_tnew();
      do_reset();
      d_I = LW;
      step();
      tests++;
      if ({ex_A3, ex_Tnew} !== {5'd8, 2'd2}) begin
         fails++;
         $display("FAIL lw_ex: got %0d/%0d expected 8/2", ex_A3, ex_Tnew);
      end
      d_I = 32'd0;
      step();
      tests++;
      if ({mem_A3, mem_Tnew} !== {5'd8, 2'd1}) begin
         fails++;
         $display("FAIL lw_mem: got %0d/%0d expected 8/1", mem_A3, mem_Tnew);
      end
      step();
      tests++;
      if ({wb_I, wb_A3} !== {LW, 5'd8}) begin
         fails++;
         $display("FAIL lw_wb: got %h/%0d expected %h/8", wb_I, wb_A3, LW);
      end
   endtask

   task automatic test_stall();
      do_reset();
      d_I = ADDU;
      step();
      d_I = LW;
      stall = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         step();
         tests++;
         if ({ex_I, ex_A3, ex_Tnew, stall_cnt} !== {32'd0, 5'd0, 2'd0, 32'(i)}) begin
            fails++;
            $display("FAIL stall_bubble%0d: got %h/%0d/%0d cnt %0d expected 0/0/0 cnt %0d",
                     i, ex_I, ex_A3, ex_Tnew, stall_cnt, i);
         end
      end
      tests++;
      if ({mem_I, wb_I} !== {32'd0, ADDU}) begin
         fails++;
         $display("FAIL stall_advance: got mem %h wb %h expected 0 %h", mem_I, wb_I, ADDU);
      end
      stall = 1'b0;
      step();
      tests++;
      if ({ex_I, ex_A3, ex_Tnew, stall_cnt} !== {LW, 5'd8, 2'd2, 32'd2}) begin
         fails++;
         $display("FAIL stall_release: got %h/%0d/%0d cnt %0d expected %h/8/2 cnt 2",
                  ex_I, ex_A3, ex_Tnew, stall_cnt, LW);
      end
      d_I = ORI;
      #2 stall = 1'b1;
      #2 stall = 1'b0;
      step();
      tests++;
      if ({ex_I, stall_cnt} !== {ORI, 32'd2}) begin
         fails++;
         $display("FAIL stall_glitch: got %h cnt %0d expected %h cnt 2", ex_I, stall_cnt, ORI);
      end
   endtask

   task automatic test_decode();
      logic [31:0] instrs [9];
      logic [6:0]  exp    [9];
      instrs = '{32'h0c000010, 32'hac280000, 32'h10220003, 32'hfc000000, 32'h03e00008,
                 32'h00221823, 32'h3c010001, 32'h0022182a, 32'h00220021};
      exp    = '{{5'd31, 2'd0}, 7'd0, 7'd0, 7'd0, 7'd0,
                 {5'd3, 2'd1}, {5'd1, 2'd1}, 7'd0, {5'd0, 2'd1}};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         d_I = instrs[i];
         step();
         tests++;
         if ({ex_I, ex_A3, ex_Tnew} !== {instrs[i], exp[i]}) begin
            fails++;
            $display("FAIL decode_%h: got %h/%0d/%0d expected %h/%0d/%0d", instrs[i],
                     ex_I, ex_A3, ex_Tnew, instrs[i], exp[i][6:2], exp[i][1:0]);
         end
      end
   endtask

   task automatic test_midop_reset();
      do_reset();
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      d_I = ORI;  step();
      d_I = ADDU; step();
      d_I = LW;   step();
      tests++;
      if ({ex_I, mem_I, wb_I, stall_cnt} !== {LW, ADDU, ORI, 32'd5}) begin
         fails++;
         $display("FAIL midop_setup: got %h %h %h cnt %0d expected %h %h %h cnt 5",
                  ex_I, mem_I, wb_I, stall_cnt, LW, ADDU, ORI);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (all_out !== 147'd0) begin
         fails++;
         $display("FAIL midop_reset: got %h expected 0", all_out);
      end
      #1 reset = 1'b0;
      d_I = ADDU;
      step();
      tests++;
      if ({ex_I, ex_A3, mem_I, stall_cnt} !== {ADDU, 5'd1, 32'd0, 32'd0}) begin
         fails++;
         $display("FAIL midop_after: got %h/%0d mem %h cnt %0d expected %h/1 mem 0 cnt 0",
                  ex_I, ex_A3, mem_I, stall_cnt, ADDU);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      stall = 1'b0;
      d_I   = 32'd0;
      step();
      test_reset();
      test_shift();
      test_lw_tnew();
      test_stall();
      test_decode();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
